// File: rtl/keypad_hex_encoder.sv
// Scans a 4x4 active-low keypad and emits one debounced 4-bit hex code per press.
// Latency: key_valid one cycle after the DEBOUNCE_CNT-th stable frame end (frame = 4*SCAN_DIV cycles).
// Backpressure: none; key_valid is a one-cycle strobe and key_code holds until the next accepted key.
module keypad_hex_encoder #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

    logic [3:0]    col_s1, col_s2;
    logic [SW-1:0] slot_cnt;
    logic [1:0]    row_idx;
    logic [1:0]    acc_n;
    logic [3:0]    acc_code;
    state_t        state, state_nxt;
    logic [3:0]    cand, cand_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [CW-1:0] rel, rel_nxt, rel_inc;
    logic [3:0]    code_nxt;
    logic          valid_nxt, held_nxt, accept;

    logic          sample_now, frame_end;
    logic [3:0]    low;
    logic [2:0]    low_pop, tot;
    logic [1:0]    tot_sat, low_col;
    logic [3:0]    frame_code;
    logic          res_none, res_single;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  4'hF: k = 4'hD;
        endcase
        return k;
    endfunction

    assign row_out    = ~(4'b0001 << row_idx);
    assign sample_now = (slot_cnt == SLOT_LAST);
    assign frame_end  = sample_now && (row_idx == 2'd3);
    assign low        = ~col_s2;
    assign low_pop    = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
    assign tot        = {1'b0, acc_n} + low_pop;
    // Only "none / one / many" matters, so the frame count saturates at 2.
    assign tot_sat    = (tot > 3'd1) ? 2'd2 : tot[1:0];
    assign res_none   = (tot_sat == 2'd0);
    assign res_single = (tot_sat == 2'd1);
    assign cnt_inc    = cnt + CW'(1);
    assign rel_inc    = rel + CW'(1);

    always_comb begin
        low_col = 2'd0;
        if (low[3]) low_col = 2'd3;
        if (low[2]) low_col = 2'd2;
        if (low[1]) low_col = 2'd1;
        if (low[0]) low_col = 2'd0;
    end

    assign frame_code = (low_pop == 3'd1) ? key_map(row_idx, low_col) : acc_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1   <= 4'b1111;
            col_s2   <= 4'b1111;
            slot_cnt <= '0;
            row_idx  <= 2'd0;
            acc_n    <= 2'd0;
            acc_code <= 4'h0;
        end else begin
            col_s1 <= col_in;
            col_s2 <= col_s1;
            if (sample_now) begin
                slot_cnt <= '0;
                row_idx  <= row_idx + 2'd1;
                if (frame_end) begin
                    acc_n    <= 2'd0;
                    acc_code <= 4'h0;
                end else begin
                    acc_n    <= tot_sat;
                    acc_code <= frame_code;
                end
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        rel_nxt   = rel;
        code_nxt  = key_code;
        valid_nxt = 1'b0;
        held_nxt  = key_held;
        accept    = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (res_single) begin
                        cand_nxt = frame_code;
                        cnt_nxt  = CW'(1);
                        if (DB_MAX == CW'(1)) accept = 1'b1;
                        else                  state_nxt = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (res_single && (frame_code == cand)) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == DB_MAX) accept = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                HELD: begin
                    if (res_none) begin
                        rel_nxt = rel_inc;
                        if (rel_inc == DB_MAX) begin
                            held_nxt  = 1'b0;
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        rel_nxt = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (accept) begin
                code_nxt  = cand_nxt;
                valid_nxt = 1'b1;
                held_nxt  = 1'b1;
                state_nxt = HELD;
                rel_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= 4'h0;
            cnt       <= '0;
            rel       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            rel       <= rel_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            key_held  <= held_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_hex_encoder.sv
// Bench for keypad_hex_encoder: a keypad model drives col_in from row_out and a
// frame-level reference model predicts row_out, key_valid, key_held and key_code every cycle.
module tb_keypad_hex_encoder;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FR = 4 * SD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    keypad_hex_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Physical keypad: bit r*4+c of pressed shorts row r to column c.
    logic [15:0] pressed = 16'h0;
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row_out[r])
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4+c]) col_in[c] = 1'b0;
    end

    int keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    int n_cmp = 0;
    int n_bad = 0;
    int n, pulses, last_pulse_n, p0;
    int m_run, m_cand, m_held, m_rel, m_code;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    // -1 = no key, -2 = several keys, otherwise the hex value of the single key.
    function automatic int frame_key(input logic [15:0] m);
        int k;
        if ($countones(m) == 0) return -1;
        if ($countones(m) > 1)  return -2;
        k = 0;
        for (int i = 0; i < 16; i++) if (m[i]) k = keymap[i];
        return k;
    endfunction

    task automatic model_frame(output bit v);
        int k;
        k = frame_key(pressed);
        v = 1'b0;
        if (m_held != 0) begin
            if (k == -1) begin
                m_rel++;
                if (m_rel == DB) m_held = 0;
            end else begin
                m_rel = 0;
            end
        end else begin
            if (k >= 0 && m_run > 0 && k == m_cand) m_run++;
            else if (k >= 0 && m_run == 0) begin m_cand = k; m_run = 1; end
            else m_run = 0;
            if (m_run == DB) begin
                v = 1'b1; m_code = m_cand; m_held = 1; m_rel = 0; m_run = 0;
            end
        end
    endtask

    task automatic reset_model();
        m_run = 0; m_cand = 0; m_held = 0; m_rel = 0; m_code = 0; n = 0;
    endtask

    task automatic step();
        bit v;
        logic [3:0] er;
        @(posedge clk);
        #1;
        n++;
        v = 1'b0;
        if (n % FR == 0) model_frame(v);
        er = 4'hF;
        er[(n / SD) % 4] = 1'b0;
        chk("row_out", row_out, er);
        chk("key_valid", key_valid, v);
        chk("key_held", key_held, m_held);
        chk("key_code", key_code, m_code);
        if (key_valid) begin pulses++; last_pulse_n = n; end
    endtask

    task automatic run(input logic [15:0] m, input int frames);
        pressed = m;
        repeat (frames * FR) step();
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_row"},   row_out,   4'b1110);
        chk({pfx, "_code"},  key_code,  4'h0);
        chk({pfx, "_valid"}, key_valid, 1'b0);
        chk({pfx, "_held"},  key_held,  1'b0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
    endtask

    initial begin
        logic [15:0] m;
        int sel, b1, b2;
        pulses = 0; last_pulse_n = 0; reset_model();
        #1;
        chk_reset("reset");
        release_reset();

        run(16'h0, 2);
        chk("scan_no_valid", pulses, 0);

        p0 = pulses;
        run(16'h1 << 6, 5);
        chk("clean_pulses", pulses - p0, 1);
        chk("clean_code", key_code, 4'h6);
        chk("clean_held", key_held, 1'b1);

        run(16'h0, 3);
        chk("release_held", key_held, 1'b0);
        chk("release_code", key_code, 4'h6);
        run(16'h0, 1);

        p0 = pulses;
        run(16'h1 << 13, 2);
        run(16'h0, 1);
        run(16'h1 << 13, 3);
        chk("bounce_pulses", pulses - p0, 1);
        chk("bounce_code", key_code, 4'h0);
        run(16'h0, 3);

        p0 = pulses;
        run(16'h0009, 4);
        chk("multi_pulses", pulses - p0, 0);
        run(16'h1 << 3, 3);
        chk("accept_a_code", key_code, 4'hA);
        p0 = pulses;
        run(16'h1 << 10, 3);
        chk("change_pulses", pulses - p0, 0);
        chk("change_held", key_held, 1'b1);
        run(16'h0, 3);

        pressed = 16'h1 << 5;
        repeat (FR + 5) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        release_reset();
        p0 = pulses;
        run(16'h1 << 5, 4);
        chk("midrst_pulses", pulses - p0, 1);
        chk("midrst_latency", last_pulse_n, 3 * FR);
        run(16'h0, 3);

        repeat (30) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) m = 16'h0;
            else if (sel < 8) m = 16'h1 << $urandom_range(0, 15);
            else begin
                b1 = $urandom_range(0, 15);
                b2 = (b1 + 1 + $urandom_range(0, 14)) % 16;
                m = (16'h1 << b1) | (16'h1 << b2);
            end
            run(m, $urandom_range(1, 5));
        end
        run(16'h0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
